gray_counter_ud: RTL

Parametrised up/down Gray-code counter with synchronous clear, Gray-value load, saturate-or-wrap mode and a combinational next-value lookahead. It keeps a binary count and its registered Gray image in lock-step. It is the pointer element for the async FIFO family: one instance per FIFO side, with `gray_o` crossing domains and `gray_next_o` feeding the registered full/empty compare. It replaces the fixed up-only Gray counter in new designs.

---
 rtl/gray_counter_ud_if.sv | 27 ++
 rtl/gray_counter_ud.sv | 87 ++++++++
 2 files changed

// File: rtl/gray_counter_ud_if.sv
// Control and status bundle for gray_counter_ud.
// The counter sits on the slave side; the pointer owner drives the master side.
interface gray_counter_ud_if #(
    parameter int unsigned W = 4
);
    logic         clr;
    logic         ld;
    logic [W-1:0] ld_gray;
    logic         en;
    logic         dir;
    logic [W-1:0] bin_o;
    logic [W-1:0] gray_o;
    logic [W-1:0] gray_next_o;
    logic         at_max_o;
    logic         at_min_o;
    logic         wrap_o;

    modport master (
        output clr, ld, ld_gray, en, dir,
        input  bin_o, gray_o, gray_next_o, at_max_o, at_min_o, wrap_o
    );

    modport slave (
        input  clr, ld, ld_gray, en, dir,
        output bin_o, gray_o, gray_next_o, at_max_o, at_min_o, wrap_o
    );
endinterface

// File: rtl/gray_counter_ud.sv
// Up/down Gray-code pointer counter with clear, Gray load and saturate-or-wrap mode.
// Binary count and its Gray image are registered together so gray_o never lags bin_o.
module gray_counter_ud #(
    parameter int unsigned W        = 4,
    parameter int unsigned INIT_BIN = 0,
    parameter bit          SATURATE = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    gray_counter_ud_if.slave bus
);
    localparam logic [W-1:0] InitBin = W'(INIT_BIN);
    localparam logic [W-1:0] MaxVal  = '1;
    localparam logic [W-1:0] MinVal  = '0;

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int i = int'(W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q;
    logic         at_max_q, at_min_q;
    logic         wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.clr) begin
            bin_d = InitBin;
        end else if (bus.ld) begin
            bin_d = gray2bin(bus.ld_gray);
        end else if (bus.en) begin
            if (bus.dir) begin
                if (bin_q == MaxVal) begin
                    if (!SATURATE) begin
                        bin_d  = MinVal;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + W'(1);
                end
            end else begin
                if (bin_q == MinVal) begin
                    if (!SATURATE) begin
                        bin_d  = MaxVal;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - W'(1);
                end
            end
        end
    end

    // Flags are derived from bin_d so they line up with bin_o on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= InitBin;
            gray_q   <= bin2gray(InitBin);
            at_max_q <= (InitBin == MaxVal);
            at_min_q <= (InitBin == MinVal);
            wrap_q   <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= bin2gray(bin_d);
            at_max_q <= (bin_d == MaxVal);
            at_min_q <= (bin_d == MinVal);
            wrap_q   <= wrap_d;
        end
    end

    assign bus.bin_o       = bin_q;
    assign bus.gray_o      = gray_q;
    assign bus.gray_next_o = bin2gray(bin_d);
    assign bus.at_max_o    = at_max_q;
    assign bus.at_min_o    = at_min_q;
    assign bus.wrap_o      = wrap_q;
endmodule
